// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite definitions for the slave-side interconnect:
//   - HTRANS encodings and HRESP values
//   - default-slave FSM state type
//   - default memory map (ROM, SRAM, AHB-to-APB bridge) bases and masks
//   - htrans_is_active(): NONSEQ/SEQ are real transfers, IDLE/BUSY are not
// ---------------------------------------------------------------------------
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [31:0] ROM_BASE  = 32'h0000_0000;
  localparam logic [31:0] ROM_MASK  = 32'hFFFF_F000;
  localparam logic [31:0] SRAM_BASE = 32'h0010_0000;
  localparam logic [31:0] SRAM_MASK = 32'hFFFF_F000;
  localparam logic [31:0] APB_BASE  = 32'h0020_0000;
  localparam logic [31:0] APB_MASK  = 32'hFFFF_0000;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  function automatic logic htrans_is_active(input logic [1:0] htrans);
    logic active;
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
      default:                   active = 1'b0;
    endcase
    return active;
  endfunction

endpackage

// File: rtl/ahb_slave_mux_if.sv
// ---------------------------------------------------------------------------
// ahb_slave_mux_if
// Bus bundle around the slave-side interconnect.
//   Upstream (shared master bus): HADDR, HTRANS in; HRDATA, HREADY, HRESP out.
//   Downstream (external slaves): HSEL_S out; HRDATA_S, HREADYOUT_S, HRESP_S in.
// modport slave  : the interconnect itself.
// modport master : everything around it (masters plus the external slaves).
// ---------------------------------------------------------------------------
interface ahb_slave_mux_if #(
  parameter int NUM_SLAVES = 3
);

  logic [31:0]              HADDR;
  logic [1:0]               HTRANS;
  logic [NUM_SLAVES-1:0]    HSEL_S;
  logic [NUM_SLAVES*32-1:0] HRDATA_S;
  logic [NUM_SLAVES-1:0]    HREADYOUT_S;
  logic [NUM_SLAVES-1:0]    HRESP_S;
  logic [31:0]              HRDATA;
  logic                     HREADY;
  logic                     HRESP;

  modport slave (
    input  HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
    output HSEL_S, HRDATA, HREADY, HRESP
  );

  modport master (
    output HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
    input  HSEL_S, HRDATA, HREADY, HRESP
  );

endinterface

// File: rtl/ahb_default_slave.sv
// ---------------------------------------------------------------------------
// ahb_default_slave
// Built-in responder for accesses that hit no mapped region. Answers an
// active unmapped transfer with the two-cycle AHB ERROR response and records
// the offending address plus a saturating error count.
// Ports:
//   HCLK, HRESET     clock, synchronous active-high reset
//   HREADY           bus-level ready (address phase is sampled only when high)
//   unmapped_active  current address phase is NONSEQ/SEQ and matches no slave
//   HADDR            current address
//   HREADYOUT, HRESP response while the default slave owns the data phase
//   err_count        saturating decode-error count
//   err_addr         address of the most recent decode error
// ---------------------------------------------------------------------------
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HREADY,
  input  logic        unmapped_active,
  input  logic [31:0] HADDR,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [7:0]  err_count,
  output logic [31:0] err_addr
);

  ds_state_e   state_q, state_d;
  logic [7:0]  err_count_q, err_count_d;
  logic [31:0] err_addr_q, err_addr_d;

  // ERR2 behaves like IDLE for sampling: a new unmapped transfer accepted on
  // the ERR2 edge starts the next ERROR pair straight away with no gap.
  // Capture happens exactly on ERR1 entry, which is the accepting edge.
  always_comb begin
    state_d     = state_q;
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    case (state_q)
      DS_IDLE, DS_ERR2: begin
        if (HREADY && unmapped_active) begin
          state_d = DS_ERR1;
        end else begin
          state_d = DS_IDLE;
        end
      end
      DS_ERR1: state_d = DS_ERR2;
      default: state_d = DS_IDLE;
    endcase
    if (state_d == DS_ERR1) begin
      err_addr_d = HADDR;
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= DS_IDLE;
      err_count_q <= 8'd0;
      err_addr_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign HREADYOUT = (state_q != DS_ERR1);
  assign HRESP     = (state_q == DS_IDLE) ? HRESP_OKAY : HRESP_ERROR;
  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;

endmodule

// File: rtl/ahb_slave_mux.sv
// ---------------------------------------------------------------------------
// ahb_slave_mux
// AHB-Lite slave-side interconnect: decodes the shared address phase into
// per-slave HSEL, remembers which slave owns the data phase, and steers that
// slave's HRDATA/HREADYOUT/HRESP back to the bus. Unmapped accesses go to the
// built-in default slave.
// Ports:
//   HCLK, HRESET  clock, synchronous active-high reset
//   bus           ahb_slave_mux_if.slave (shared bus + per-slave signals)
//   err_count     saturating decode-error count
//   err_addr      HADDR of the last unmapped active transfer
// Parameters:
//   NUM_SLAVES    external slaves (1..8)
//   BASE_VEC      packed region bases, slice i belongs to slave i
//   MASK_VEC      packed region masks, slice i belongs to slave i
// ---------------------------------------------------------------------------
module ahb_slave_mux
  import ahb_pkg::*;
#(
  parameter int                       NUM_SLAVES = 3,
  parameter logic [NUM_SLAVES*32-1:0] BASE_VEC   = {APB_BASE, SRAM_BASE, ROM_BASE},
  parameter logic [NUM_SLAVES*32-1:0] MASK_VEC   = {APB_MASK, SRAM_MASK, ROM_MASK}
) (
  input  logic             HCLK,
  input  logic             HRESET,
  ahb_slave_mux_if.slave   bus,
  output logic [7:0]       err_count,
  output logic [31:0]      err_addr
);

  logic [NUM_SLAVES-1:0] hsel;
  logic                  hit;
  logic                  unmapped_active;
  logic [NUM_SLAVES:0]   dsel_q, dsel_d;
  logic                  def_ready;
  logic                  def_resp;
  logic [31:0]           hrdata_mux;
  logic                  hready_mux;
  logic                  hresp_mux;

  // Address decode. The first matching region claims the select so that
  // overlapping regions still give a one-hot (or empty) HSEL. HTRANS is left
  // out on purpose; slaves qualify their own select.
  always_comb begin
    hsel = '0;
    hit  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!hit && ((bus.HADDR & MASK_VEC[i*32 +: 32]) == BASE_VEC[i*32 +: 32])) begin
        hsel[i] = 1'b1;
        hit     = 1'b1;
      end
    end
  end

  assign bus.HSEL_S      = hsel;
  assign unmapped_active = htrans_is_active(bus.HTRANS) && !hit;

  // Data-phase owner. The top bit is the default slave. It only moves when
  // the bus is ready, so a wait-stated data phase keeps its owner.
  always_comb begin
    dsel_d = dsel_q;
    if (bus.HREADY) begin
      dsel_d = {!hit, hsel};
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dsel_q <= {1'b1, {NUM_SLAVES{1'b0}}};
    end else begin
      dsel_q <= dsel_d;
    end
  end

  ahb_default_slave u_default_slave (
    .HCLK            (HCLK),
    .HRESET          (HRESET),
    .HREADY          (bus.HREADY),
    .unmapped_active (unmapped_active),
    .HADDR           (bus.HADDR),
    .HREADYOUT       (def_ready),
    .HRESP           (def_resp),
    .err_count       (err_count),
    .err_addr        (err_addr)
  );

  // Response steering from the data-phase owner. The default slave never
  // returns data, so HRDATA reads as zero while it owns the phase.
  always_comb begin
    hrdata_mux = '0;
    hready_mux = 1'b0;
    hresp_mux  = HRESP_OKAY;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel_q[i]) begin
        hrdata_mux = bus.HRDATA_S[i*32 +: 32];
        hready_mux = bus.HREADYOUT_S[i];
        hresp_mux  = bus.HRESP_S[i];
      end
    end
    if (dsel_q[NUM_SLAVES]) begin
      hready_mux = def_ready;
      hresp_mux  = def_resp;
    end
  end

  assign bus.HRDATA = hrdata_mux;
  assign bus.HREADY = hready_mux;
  assign bus.HRESP  = hresp_mux;

endmodule
